// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle sequencing controller.
package paddle_pkg;

    localparam int NUM_ROWS = 128;

    typedef logic [6:0] row_t;

    typedef enum logic [1:0] {
        INIT,
        PLAY,
        DEAD
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DN
    } dir_t;

endpackage

// File: rtl/paddle_ctrl_move_rate_limiter.sv
// Turns a level direction request into move strobes: a fresh request or a
// direction change strobes at once, a held request strobes every MOVE_DIV cycles.
module move_rate_limiter
    import paddle_pkg::*;
#(
    parameter int MOVE_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic       strobe
);

    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MOVE_DIV - 1);

    dir_t             req_dir;
    dir_t             last_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign req_dir = dir_t'(req);
    assign strobe  = (req_dir != NONE) && ((req_dir != last_reg) || (cnt_reg == '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_reg <= NONE;
            cnt_reg  <= '0;
        end else if (req_dir == NONE) begin
            last_reg <= NONE;
            cnt_reg  <= '0;
        end else begin
            last_reg <= req_dir;
            if (strobe) begin
                cnt_reg <= RELOAD;
            end else begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle sequencer: rate-limited, boundary-checked shift pulses plus hit/miss judging.
// Optional PADDLE_AI_EN adds an ai_mode input that tracks ball_y instead of the buttons.
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int PADDLE_W = 16,
    parameter int MOVE_DIV = 4,
    parameter int POS_INIT = 56
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       moveUp,
    input  logic       moveDown,
    input  logic       restart,
    input  logic       inPaddleRange,
    input  logic [6:0] ball_y,
`ifdef PADDLE_AI_EN
    input  logic       ai_mode,
`endif
    output logic       reg_reset,
    output logic       reg_kill,
    output logic       reg_left,
    output logic       reg_right,
    output logic [6:0] pos,
    output logic       isHit,
    output logic       isMiss
);

    state_t     state_reg;
    row_t       pos_reg;
    logic       in_range_prev_reg;
    logic       reg_reset_reg;
    logic       reg_kill_reg;
    logic       reg_left_reg;
    logic       reg_right_reg;
    logic       is_hit_reg;
    logic       is_miss_reg;

    dir_t       req_dir;
    logic       move_strobe;
    logic [7:0] pos_ext;
    logic [7:0] ball_ext;
    logic [7:0] top_row;
    logic       up_legal;
    logic       dn_legal;
    logic       judge;
    logic       ball_hit;

    // 8-bit arithmetic keeps pos + PADDLE_W from wrapping.
    assign pos_ext  = {1'b0, pos_reg};
    assign ball_ext = {1'b0, ball_y};
    assign top_row  = pos_ext + 8'(PADDLE_W) - 8'd1;
    assign up_legal = (pos_ext + 8'(PADDLE_W)) <= 8'(NUM_ROWS - 1);
    assign dn_legal = (pos_reg != '0);
    assign judge    = (state_reg == PLAY) && inPaddleRange && !in_range_prev_reg;
    assign ball_hit = (ball_ext >= pos_ext) && (ball_ext <= top_row);

`ifdef PADDLE_AI_EN
    logic [7:0] mid_row;
    assign mid_row = pos_ext + 8'(PADDLE_W / 2);
`endif

    // Requests outside PLAY read as NONE so the limiter counter stays cleared.
    always_comb begin
        req_dir = NONE;
        if (state_reg == PLAY) begin
`ifdef PADDLE_AI_EN
            if (ai_mode) begin
                if (ball_ext > mid_row) begin
                    req_dir = UP;
                end else if (ball_ext < mid_row) begin
                    req_dir = DN;
                end
            end else
`endif
            if (moveUp && !moveDown) begin
                req_dir = UP;
            end else if (moveDown && !moveUp) begin
                req_dir = DN;
            end
        end
    end

    move_rate_limiter #(
        .MOVE_DIV (MOVE_DIV)
    ) u_limiter (
        .clk    (clk),
        .reset  (reset),
        .req    (req_dir),
        .strobe (move_strobe)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= INIT;
            pos_reg           <= row_t'(POS_INIT);
            in_range_prev_reg <= 1'b0;
            reg_reset_reg     <= 1'b0;
            reg_kill_reg      <= 1'b0;
            reg_left_reg      <= 1'b0;
            reg_right_reg     <= 1'b0;
            is_hit_reg        <= 1'b0;
            is_miss_reg       <= 1'b0;
        end else begin
            in_range_prev_reg <= inPaddleRange;
            reg_reset_reg     <= 1'b0;
            reg_kill_reg      <= 1'b0;
            reg_left_reg      <= 1'b0;
            reg_right_reg     <= 1'b0;
            is_hit_reg        <= 1'b0;
            is_miss_reg       <= 1'b0;
            case (state_reg)
                INIT: begin
                    reg_reset_reg <= 1'b1;
                    pos_reg       <= row_t'(POS_INIT);
                    state_reg     <= PLAY;
                end
                PLAY: begin
                    if (judge && !ball_hit) begin
                        is_miss_reg  <= 1'b1;
                        reg_kill_reg <= 1'b1;
                        state_reg    <= DEAD;
                    end else begin
                        is_hit_reg <= judge;
                        // Illegal moves are dropped here; the limiter still reloads.
                        if (move_strobe && (req_dir == UP) && up_legal) begin
                            reg_left_reg <= 1'b1;
                            pos_reg      <= pos_reg + 7'd1;
                        end else if (move_strobe && (req_dir == DN) && dn_legal) begin
                            reg_right_reg <= 1'b1;
                            pos_reg       <= pos_reg - 7'd1;
                        end
                    end
                end
                DEAD: begin
                    if (restart) begin
                        state_reg <= INIT;
                    end
                end
                default: state_reg <= INIT;
            endcase
        end
    end

    assign reg_reset = reg_reset_reg;
    assign reg_kill  = reg_kill_reg;
    assign reg_left  = reg_left_reg;
    assign reg_right = reg_right_reg;
    assign pos       = pos_reg;
    assign isHit     = is_hit_reg;
    assign isMiss    = is_miss_reg;

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Sequencing controller for one paddle's 128-bit shift register (`Register128bit`). It turns raw `moveUp`/`moveDown` buttons into rate-limited, boundary-checked single-cycle shift pulses. It tracks the paddle's position and issues the register's reset/kill pulses. When the ball reaches the paddle column, it judges hit or miss. It sits between the button inputs and ball engine on one side and the paddle register plus score logic on the other.

## Interface
- `PADDLE_W`, 16: paddle height in rows, 1..127.
- `MOVE_DIV`, 4: cycles between repeated moves while a button is held, ≥1.
- `POS_INIT`, 56: paddle bottom row after init; requires `POS_INIT + PADDLE_W ≤ 128`.
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `moveUp`  in  1: up request (level).
- `moveDown`  in  1: down request (level).
- `restart`  in  1: leave DEAD and re-initialise (level, sampled in DEAD only).
- `inPaddleRange`  in  1: ball is in the paddle column.
- `ball_y`  in  7: ball row, 0..127.
- `reg_reset`  out  1: one-cycle pulse that loads the register's default pattern.
- `reg_kill`  out  1: one-cycle pulse that clears the register.
- `reg_left`  out  1: one-cycle pulse to shift the register toward higher rows (up).
- `reg_right`  out  1: one-cycle pulse to shift the register toward lower rows (down).
- `pos`  out  7: current paddle bottom row; the paddle occupies `pos .. pos+PADDLE_W-1`.
- `isHit`  out  1: one-cycle pulse, ball hit the paddle.
- `isMiss`  out  1: one-cycle pulse, ball missed the paddle.

## Operation
- FSM states and transitions:
  - INIT: assert `reg_reset` and load `pos = POS_INIT`, then go to PLAY.
  - PLAY: handle moves and judging (rules below).
  - DEAD: emit no pulses. If `restart` is 1, go to INIT.
- Move request: `up = moveUp & ~moveDown`; `dn = moveDown & ~moveUp`. If both or neither are pressed, no request is made and the repeat counter clears.
- Rate limiter: a new request (idle → dir, or a direction change) moves immediately and loads the counter with `MOVE_DIV-1`.
  - While the same direction is held, the counter decrements.
  - When it reaches 0, one move is made and the counter reloads.
- Boundaries:
  - An up move is legal only if `pos + PADDLE_W ≤ 127`.
  - A down move is legal only if `pos ≥ 1`.
  - An illegal move emits no pulse and leaves `pos` unchanged, but the counter still reloads.
- Judging: performed once per rising edge of `inPaddleRange` (previous value registered) while in PLAY.
  - Hit when `pos ≤ ball_y ≤ pos+PADDLE_W-1`, computed at 8-bit width so there is no overflow.
  - Hit → `isHit` pulse.
  - Miss → `isMiss` and `reg_kill` pulses together, and the FSM goes to DEAD.
- Simultaneous events:
  - Judging uses the pre-update `pos`.
  - On a miss cycle, no move pulse is issued.
  - On a hit cycle, a move still occurs.
- `inPaddleRange` held high produces no repeat judging. A rising edge of `inPaddleRange` seen in DEAD or INIT is ignored.

## Timing
- Reset (`reset` = 0 at an edge): state goes to INIT; `pos = POS_INIT`; all pulse outputs, the counter, and the previous-`inPaddleRange` register go to 0. Reset mid-move or mid-DEAD aborts immediately.
- `reg_reset` is high for exactly the cycle after the first edge with `reset` = 1. PLAY begins on the following edge.
- All outputs are registered.
- A move pulse appears one cycle after its request is sampled, and `pos` updates in the same cycle as the pulse.
- `isHit`/`isMiss`/`reg_kill` appear one cycle after the sampled `inPaddleRange` rising edge.
- `reg_left` and `reg_right` are never both high. No pulse is wider than one cycle.
- Sustained held rate is one move every `MOVE_DIV` cycles. With `MOVE_DIV` = 1, a move occurs every cycle.

## Configuration
- `PADDLE_AI_EN`: adds input `ai_mode` (1 bit).
  - When `ai_mode` = 1, the buttons are ignored. The controller generates `up` if `ball_y > pos + PADDLE_W/2`, `dn` if `ball_y < pos + PADDLE_W/2`, and otherwise no request.
  - Auto-generated requests go through the same rate limiter and boundary checks.
  - When the macro is undefined, the port and logic are absent and behaviour is buttons-only.

## Structure
- Package `paddle_pkg`:
  - `NUM_ROWS = 128`
  - row type (7-bit)
  - FSM state enum {INIT, PLAY, DEAD}
  - direction enum {NONE, UP, DN}
- Sub-module `move_rate_limiter`: takes a direction request, outputs a move strobe, and contains the counter and direction-change detect. It is instantiated once.

## Test plan
All scenarios use the defaults `PADDLE_W` = 16, `MOVE_DIV` = 4, `POS_INIT` = 56.
- Reset release → `reg_reset` 1 for one cycle; `pos` = 56; no other pulses; state becomes PLAY.
- Hold `moveUp` for 9 cycles → `reg_left` pulses at cycles 1, 5, 9; `pos` = 59.
- `pos` = 112, hold `moveUp` → no `reg_left`, `pos` stays 112. At `pos` = 0, `moveDown` → no `reg_right`.
- `moveUp` and `moveDown` both high for 10 cycles → no shift pulses; `pos` unchanged.
- `pos` = 56, `ball_y` = 71, `inPaddleRange` rises → `isHit` one cycle later. Holding `inPaddleRange` high gives no second pulse.
- `pos` = 56, `ball_y` = 72, rising edge → `isMiss` + `reg_kill`, state DEAD, buttons ignored. `restart` → `reg_reset` pulse, `pos` = 56, PLAY.
